hsem_ine_mc: RTL and testbench

Parametrised multi-core interrupt/error controller for the HSEM, replacing the fixed two-core controller. Each of `NUM_CORES` cores gets:
- a sticky error register with overflow flag;
- an interrupt status register with software set, write-1-to-clear and mask;
- a per-core level or pulse delivery mode.

It sits between the HSEM bus-register decode (which supplies `core_sel`/`reg_sel`) and the per-core interrupt lines at the top level.

---
 rtl/hsem_ine_pkg.sv | 30 +++
 rtl/hsem_ine_core.sv | 124 ++++++++++++
 rtl/hsem_ine_mc.sv | 66 ++++++
 tb/tb_hsem_ine_mc.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsem_ine_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : hsem_ine_pkg                                                    |
// | Desc     : Register encodings and bit positions for the HSEM multi-core    |
// |            interrupt/error controller.                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package hsem_ine_pkg;

  localparam logic [2:0] REG_INT_STAT = 3'd0;
  localparam logic [2:0] REG_INT_CLR  = 3'd1;
  localparam logic [2:0] REG_ERR      = 3'd2;
  localparam logic [2:0] REG_ERR_CLR  = 3'd3;
  localparam logic [2:0] REG_INT_MASK = 3'd4;
  localparam logic [2:0] REG_CTRL     = 3'd5;
  localparam logic [2:0] REG_ERR_CNT  = 3'd6;

  localparam int   ERR_BIT       = 0;
  localparam int   CTRL_MODE_BIT = 0;
  localparam logic MASK_RST_BIT  = 1'b1;

  // ovf lives in the top bit of the ERR read word
  function automatic int ovf_bit(input int data_width);
    return data_width - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hsem_ine_core.sv
// +----------------------------------------------------------------------------+
// | Module   : hsem_ine_core                                                   |
// | Desc     : One core's status/mask/ctrl/error registers and interrupt       |
// |            delivery. Optional error counter: HSEM_INE_ERRCNT_EN.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module hsem_ine_core #(
  parameter int DATA_WIDTH   = 32,
  parameter int SEMERR_WIDTH = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    wr_en,
  input  logic [2:0]              reg_sel,
  input  logic [DATA_WIDTH-1:0]   ihwdata,
  input  logic [SEMERR_WIDTH-1:0] semerr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    intr
);
  import hsem_ine_pkg::*;

  localparam int OVF_POS = ovf_bit(DATA_WIDTH);

  logic [DATA_WIDTH-1:0]   r_status;
  logic [DATA_WIDTH-1:0]   r_mask;
  logic [DATA_WIDTH-1:0]   r_eff_prev;
  logic                    r_mode;
  logic [SEMERR_WIDTH-1:0] r_code;
  logic                    r_ovf;

  logic [DATA_WIDTH-1:0]   w_status_nxt;
  logic [DATA_WIDTH-1:0]   w_eff;
  logic [DATA_WIDTH-1:0]   w_cnt_rdata;
  logic                    w_err_evt;
  logic                    w_wr_stat;
  logic                    w_wr_clr;
  logic                    w_wr_errclr;
  logic                    w_wr_mask;
  logic                    w_wr_ctrl;

  assign w_err_evt   = |semerr;
  assign w_wr_stat   = wr_en && (reg_sel == REG_INT_STAT);
  assign w_wr_clr    = wr_en && (reg_sel == REG_INT_CLR);
  assign w_wr_errclr = wr_en && (reg_sel == REG_ERR_CLR);
  assign w_wr_mask   = wr_en && (reg_sel == REG_INT_MASK);
  assign w_wr_ctrl   = wr_en && (reg_sel == REG_CTRL);

  // hardware error set is applied last so it wins over a same-cycle W1C
  always_comb begin
    w_status_nxt = r_status;
    if (w_wr_stat) w_status_nxt = r_status | ihwdata;
    if (w_wr_clr)  w_status_nxt = r_status & ~ihwdata;
    if (w_err_evt) w_status_nxt[ERR_BIT] = 1'b1;
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_status   <= '0;
      r_mask     <= {DATA_WIDTH{MASK_RST_BIT}};
      r_eff_prev <= '0;
      r_mode     <= 1'b0;
      r_code     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_status   <= w_status_nxt;
      r_eff_prev <= w_eff;
      if (w_wr_mask) r_mask <= ihwdata;
      if (w_wr_ctrl) r_mode <= ihwdata[CTRL_MODE_BIT];
      // a clear coinciding with a new error reloads the code with ovf cleared
      if (w_wr_errclr) begin
        r_code <= semerr;
        r_ovf  <= 1'b0;
      end else if (w_err_evt) begin
        if (r_code == '0) r_code <= semerr;
        else              r_ovf  <= 1'b1;
      end
    end
  end

  assign w_eff = r_status & r_mask;
  assign intr  = r_mode ? |(w_eff & ~r_eff_prev) : |w_eff;

`ifdef HSEM_INE_ERRCNT_EN
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_wr_cnt;

  assign w_wr_cnt = wr_en && (reg_sel == REG_ERR_CNT);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_cnt <= '0;
    end else if (w_wr_cnt) begin
      r_cnt <= w_err_evt ? CNT_WIDTH'(1) : '0;
    end else if (w_err_evt && (r_cnt != {CNT_WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign w_cnt_rdata = DATA_WIDTH'(r_cnt);
`else
  assign w_cnt_rdata = '0;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_INT_STAT: rdata = r_status;
      REG_ERR: begin
        rdata[SEMERR_WIDTH-1:0] = r_code;
        rdata[OVF_POS]          = r_ovf;
      end
      REG_INT_MASK: rdata = r_mask;
      REG_CTRL:     rdata[CTRL_MODE_BIT] = r_mode;
      REG_ERR_CNT:  rdata = w_cnt_rdata;
      default:      rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hsem_ine_mc.sv
// +----------------------------------------------------------------------------+
// | Module   : hsem_ine_mc                                                     |
// | Desc     : Parametrised multi-core HSEM interrupt/error controller: core   |
// |            select decode, per-core instances and read mux.                 |
// |            Optional error counter: HSEM_INE_ERRCNT_EN.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module hsem_ine_mc #(
  parameter  int NUM_CORES    = 4,
  parameter  int DATA_WIDTH   = 32,
  parameter  int SEMERR_WIDTH = 4,
  parameter  int CNT_WIDTH    = 8,
  localparam int CORE_SEL_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                              hclk,
  input  logic                              hreset,
  input  logic                              wr_en,
  input  logic                              rd_en,
  input  logic [CORE_SEL_W-1:0]             core_sel,
  input  logic [2:0]                        reg_sel,
  input  logic [DATA_WIDTH-1:0]             ihwdata,
  input  logic [NUM_CORES*SEMERR_WIDTH-1:0] semerr,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic [NUM_CORES-1:0]              intr
);
  import hsem_ine_pkg::*;

  logic [DATA_WIDTH-1:0] w_core_rdata [NUM_CORES];
  logic [NUM_CORES-1:0]  w_core_wr;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign w_core_wr[gi] = wr_en && (core_sel == CORE_SEL_W'(gi));

      hsem_ine_core #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SEMERR_WIDTH (SEMERR_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
      ) u_core (
        .hclk    (hclk),
        .hreset  (hreset),
        .wr_en   (w_core_wr[gi]),
        .reg_sel (reg_sel),
        .ihwdata (ihwdata),
        .semerr  (semerr[gi*SEMERR_WIDTH +: SEMERR_WIDTH]),
        .rdata   (w_core_rdata[gi]),
        .intr    (intr[gi])
      );
    end
  endgenerate

  // out-of-range core_sel matches no instance and reads as zero
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_sel == CORE_SEL_W'(i)) rdata = w_core_rdata[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hsem_ine_mc.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_hsem_ine_mc                                                  |
// | Desc     : Scoreboard bench for hsem_ine_mc with a behavioural model.      |
// |            Honours HSEM_INE_ERRCNT_EN when defined.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hsem_ine_mc;
  localparam int NC  = 5;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int CW  = 8;
  localparam int CSW = 3;

  logic           hclk = 1'b0;
  logic           hreset;
  logic           wr_en;
  logic           rd_en;
  logic [CSW-1:0] core_sel;
  logic [2:0]     reg_sel;
  logic [DW-1:0]  ihwdata;
  logic [NC*SW-1:0] semerr;
  logic [DW-1:0]  rdata;
  logic [NC-1:0]  intr;

  int total = 0;
  int bad   = 0;

  int unsigned   q_rd[$];
  logic [NC-1:0] q_intr[$];

  // reference state, named after the programmer-visible registers
  int unsigned m_stat [NC];
  int unsigned m_mask [NC];
  int unsigned m_prev [NC];
  int unsigned m_code [NC];
  int unsigned m_cnt  [NC];
  bit          m_ovf  [NC];
  bit          m_mode [NC];

  hsem_ine_mc #(
    .NUM_CORES    (NC),
    .DATA_WIDTH   (DW),
    .SEMERR_WIDTH (SW),
    .CNT_WIDTH    (CW)
  ) dut (
    .hclk     (hclk),
    .hreset   (hreset),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .core_sel (core_sel),
    .reg_sel  (reg_sel),
    .ihwdata  (ihwdata),
    .semerr   (semerr),
    .rdata    (rdata),
    .intr     (intr)
  );

  always #5 hclk = ~hclk;

  function automatic void check(string name, longint unsigned act, longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_stat[c] = 0; m_mask[c] = 32'hFFFF_FFFF; m_prev[c] = 0;
      m_code[c] = 0; m_cnt[c] = 0; m_ovf[c] = 0; m_mode[c] = 0;
    end
  endfunction

  function automatic int unsigned model_read(int cs, int rs);
    if (cs >= NC) return 0;
    case (rs)
      0: return m_stat[cs];
      2: return (m_ovf[cs] ? 32'h8000_0000 : 32'h0) | m_code[cs];
      4: return m_mask[cs];
      5: return {31'b0, m_mode[cs]};
`ifdef HSEM_INE_ERRCNT_EN
      6: return m_cnt[cs];
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [NC-1:0] model_intr();
    logic [NC-1:0] v = '0;
    for (int c = 0; c < NC; c++) begin
      int unsigned eff = m_stat[c] & m_mask[c];
      v[c] = m_mode[c] ? ((eff & ~m_prev[c]) != 0) : (eff != 0);
    end
    return v;
  endfunction

  // one clock edge worth of register-map behaviour
  function automatic void model_edge(bit wr, int cs, int rs, int unsigned data, logic [NC*SW-1:0] se);
    for (int c = 0; c < NC; c++) begin
      int unsigned err = int'(se[c*SW +: SW]);
      bit hit = wr && (cs == c);
      m_prev[c] = m_stat[c] & m_mask[c];
      if (hit && rs == 0) m_stat[c] = m_stat[c] | data;
      if (hit && rs == 1) m_stat[c] = m_stat[c] & ~data;
      if (err != 0) m_stat[c] = m_stat[c] | 1;
      if (hit && rs == 3) begin
        m_code[c] = err; m_ovf[c] = 0;
      end else if (err != 0) begin
        if (m_code[c] == 0) m_code[c] = err;
        else m_ovf[c] = 1;
      end
      if (hit && rs == 4) m_mask[c] = data;
      if (hit && rs == 5) m_mode[c] = data[0];
      if (hit && rs == 6) m_cnt[c] = (err != 0) ? 1 : 0;
      else if (err != 0 && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
    end
  endfunction

  task automatic step(input bit wr, input bit rd, input int cs, input int rs,
                      input int unsigned data, input logic [NC*SW-1:0] se);
    logic [CSW-1:0] csv;
    logic [2:0]     rsv;
    @(negedge hclk);
    csv = cs[CSW-1:0];
    rsv = rs[2:0];
    wr_en = wr; rd_en = rd; core_sel = csv; reg_sel = rsv;
    ihwdata = data; semerr = se;
    q_intr.push_back(model_intr());
    if (rd) q_rd.push_back(model_read(cs, rs));
    @(posedge hclk);
    model_edge(wr, cs, rs, data, se);
  endtask

  function automatic logic [NC*SW-1:0] se_one(int c, int v);
    logic [NC*SW-1:0] s = '0;
    s[c*SW +: SW] = v[SW-1:0];
    return s;
  endfunction

  function automatic logic [NC*SW-1:0] rand_se();
    logic [NC*SW-1:0] s = '0;
    for (int c = 0; c < NC; c++)
      if ($urandom_range(0, 9) == 0) s[c*SW +: SW] = SW'($urandom_range(1, 15));
    return s;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, '0);
  endtask

  task automatic rand_run(input int n);
    for (int k = 0; k < n; k++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom, rand_se());
  endtask

  // monitor: compares whatever the DUT presents in each cycle against the queue
  initial begin
    forever begin
      @(negedge hclk);
      #2;
      if (rd_en) begin
        if (q_rd.size() == 0) check("rd_unexpected", 1, 0);
        else check("rdata", rdata, q_rd.pop_front());
      end
      if (q_intr.size() > 0) check("intr", intr, q_intr.pop_front());
    end
  end

  initial begin
    hreset = 1'b1; wr_en = 0; rd_en = 1; core_sel = '0; reg_sel = 3'd0;
    ihwdata = '0; semerr = '0;
    model_reset();
    #2;
    check("reset_intr", intr, 0);
    check("reset_rdata", rdata, 0);
    rd_en = 0;
    @(negedge hclk);
    hreset = 1'b0;

    for (int c = 0; c < NC; c++) step(0, 1, c, 4, 0, '0);

    // error capture with overflow on core 2
    step(0, 0, 0, 0, 0, se_one(2, 3));
    step(0, 0, 0, 0, 0, se_one(2, 5));
    step(0, 1, 2, 2, 0, '0);
    step(0, 1, 2, 0, 0, '0);
    step(1, 0, 2, 3, 0, '0);
    step(0, 1, 2, 2, 0, '0);

    // software set and W1C on core 1
    step(1, 0, 1, 0, 32'h30, '0);
    step(1, 0, 1, 1, 32'h10, '0);
    step(0, 1, 1, 0, 0, '0);
    step(1, 0, 1, 1, 32'h20, '0);
    idle(2);

    // pulse mode on core 0
    step(1, 0, 0, 5, 1, '0);
    step(1, 0, 0, 0, 32'h4, '0);
    idle(3);
    step(1, 0, 0, 0, 32'h4, '0);
    idle(2);
    step(1, 0, 0, 0, 32'h8, '0);
    idle(2);
    step(0, 1, 0, 5, 0, '0);

    // mask on core 3
    step(1, 0, 3, 4, 0, '0);
    step(1, 0, 3, 0, 32'h1, '0);
    idle(1);
    step(1, 0, 3, 4, 32'h1, '0);
    idle(2);

    // collisions on core 4
    step(1, 0, 4, 1, 32'h1, se_one(4, 2));
    step(0, 1, 4, 0, 0, '0);
    step(1, 0, 4, 3, 0, se_one(4, 7));
    step(0, 1, 4, 2, 0, '0);

    // counter saturation, then clear colliding with an increment
    for (int k = 0; k < 300; k++) step(0, 0, 0, 0, 0, se_one(1, 9));
    step(0, 1, 1, 6, 0, '0);
    step(1, 0, 1, 6, 0, se_one(1, 1));
    step(0, 1, 1, 6, 0, '0);
    step(1, 1, 1, 7, 32'hFFFF_FFFF, '0);

    // out-of-range core_sel
    step(1, 1, 6, 0, 32'hFF, '0);
    step(0, 1, 5, 4, 0, '0);
    step(0, 1, 7, 0, 0, '0);

    rand_run(1500);

    // async reset while core 2 is interrupting
    step(1, 0, 2, 4, 32'hFFFF_FFFF, '0);
    step(1, 0, 2, 5, 0, '0);
    step(1, 0, 2, 0, 32'h1, '0);
    idle(1);
    @(negedge hclk);
    wr_en = 0; rd_en = 0; semerr = '0;
    #3;
    rd_en = 1; core_sel = 3'd2; reg_sel = 3'd0;
    hreset = 1'b1;
    #1;
    check("async_rst_intr", intr, 0);
    check("async_rst_rdata", rdata, 0);
    rd_en = 0;
    model_reset();
    @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    for (int c = 0; c < NC; c++) step(0, 1, c, 4, 0, '0);
    step(0, 1, 2, 2, 0, '0);

    rand_run(300);
    idle(1);
    @(negedge hclk);
    #4;
    check("queue_drain", q_rd.size() + q_intr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
